// File: rtl/hex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_pkg
// Description : Shared constants for the seven-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hex_pkg;

    localparam int          c_MAX_DIGITS = 8;

    localparam logic [1:0]  c_ST_BLANK = 2'd0;
    localparam logic [1:0]  c_ST_SCAN  = 2'd1;
    localparam logic [1:0]  c_ST_PEND  = 2'd2;

    localparam logic [6:0]  c_SEG_OFF  = 7'h7F;

    // Slice the low NUM_DIGITS bits for an all-off anode word.
    localparam logic [c_MAX_DIGITS-1:0] c_AN_OFF_ALL = '1;

endpackage : hex_pkg
`default_nettype wire

// File: rtl/hex_driver.sv
`default_nettype none
// ============================================================================
// Module      : hex_driver
// Description : Nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_driver (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_nibble)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule : hex_driver
`default_nettype wire

// File: rtl/hex_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hex_scan_ctrl
// Description : Multiplexed seven-segment scanner with frame-aligned updates.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_scan_ctrl
    import hex_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic                    i_blank_lz,
    input  logic                    i_clear,
    output logic [6:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_an
);

    localparam int                    IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] c_AN_OFF = c_AN_OFF_ALL[NUM_DIGITS-1:0];

    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_scanning;
    logic                    w_tick;
    logic                    w_frame_end;
    logic                    w_accept;
    logic [NUM_DIGITS-1:0]   w_zero_from;
    logic [3:0]              w_nibble;
    logic                    w_zero_sel;
    logic [NUM_DIGITS-1:0]   w_an_sel;
    logic                    w_blank_digit;
    logic [6:0]              w_seg;

    assign w_scanning  = (r_state == c_ST_SCAN) || (r_state == c_ST_PEND);
    assign w_tick      = w_scanning && (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_frame_end = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign o_ready     = (r_state != c_ST_PEND);
    assign w_accept    = i_valid && o_ready;

    // w_zero_from[k]: nibbles k..NUM_DIGITS-1 of the display are all zero.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
        if (k == NUM_DIGITS - 1) begin : g_top
            assign w_zero_from[k] = (r_disp[4*k +: 4] == 4'h0);
        end else begin : g_lower
            assign w_zero_from[k] = (r_disp[4*k +: 4] == 4'h0) && w_zero_from[k+1];
        end
    end

    always_comb begin
        w_nibble   = 4'h0;
        w_zero_sel = 1'b0;
        w_an_sel   = c_AN_OFF;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nibble    = r_disp[4*k +: 4];
                w_zero_sel  = w_zero_from[k];
                w_an_sel[k] = 1'b0;
            end
        end
    end

    assign w_blank_digit = i_blank_lz && (r_idx != '0) && w_zero_sel;

    hex_driver u_hex_driver (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= c_ST_BLANK;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_disp   <= '0;
            r_shadow <= '0;
        end else if (i_clear) begin
            r_state  <= c_ST_BLANK;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shadow <= '0;
        end else begin
            if (w_scanning) begin
                r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
                if (w_tick) begin
                    r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
                end
            end
            case (r_state)
                c_ST_SCAN: begin
                    // A value arriving on the frame boundary needs no shadowing.
                    if (w_accept && w_frame_end) begin
                        r_disp <= i_value;
                    end else if (w_accept) begin
                        r_shadow <= i_value;
                        r_state  <= c_ST_PEND;
                    end
                end
                c_ST_PEND: begin
                    if (w_frame_end) begin
                        r_disp  <= r_shadow;
                        r_state <= c_ST_SCAN;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_disp  <= i_value;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= c_ST_SCAN;
                    end else begin
                        r_state <= c_ST_BLANK;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !w_scanning || w_blank_digit) begin
            r_seg <= c_SEG_OFF;
            r_an  <= c_AN_OFF;
        end else begin
            r_seg <= w_seg;
            r_an  <= w_an_sel;
        end
    end

    assign o_seg = r_seg;
    assign o_an  = r_an;

endmodule : hex_scan_ctrl
`default_nettype wire

// File: tb/tb_hex_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_scan_ctrl
// Description : Directed bench with a frame-position model of the scanner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_scan_ctrl;

    localparam int N = 4;
    localparam int R = 4;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [15:0]   i_value = '0;
    logic          i_blank_lz = 1'b0;
    logic          i_clear = 1'b0;
    logic [6:0]    o_seg;
    logic [N-1:0]  o_an;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    hex_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_value    (i_value),
        .i_blank_lz (i_blank_lz),
        .i_clear    (i_clear),
        .o_seg      (o_seg),
        .o_an       (o_an)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Model: m_pos is the cycle position within a frame (-1 = blank).
    int           m_pos  = -1;
    logic [15:0]  m_disp = '0;
    logic         m_pend = 1'b0;
    logic [15:0]  m_pv   = '0;
    logic         e_valid = 1'b0;
    logic [N-1:0] e_an;
    logic [6:0]   e_seg;
    logic         e_ready;

    always @(posedge clk) begin
        int   d;
        logic fe;
        if (i_rst) begin
            e_an = '1; e_seg = 7'h7F; e_valid = 1'b1;
            m_pos = -1; m_disp = '0; m_pend = 1'b0; m_pv = '0;
        end else begin
            e_an = '1; e_seg = 7'h7F;
            if (m_pos >= 0) begin
                d = m_pos / R;
                if (!(i_blank_lz && d > 0 && (m_disp >> (4*d)) == 16'h0)) begin
                    e_an  = ~(N'(1) << d);
                    e_seg = seg_of(4'((m_disp >> (4*d)) & 16'hF));
                end
            end
            if (i_clear) begin
                m_pos = -1; m_pend = 1'b0;
            end else if (m_pos < 0) begin
                if (i_valid) begin m_disp = i_value; m_pos = 0; end
            end else begin
                fe = (m_pos == N*R - 1);
                if (i_valid && !m_pend) begin
                    if (fe) m_disp = i_value;
                    else begin m_pend = 1'b1; m_pv = i_value; end
                end else if (m_pend && fe) begin
                    m_disp = m_pv; m_pend = 1'b0;
                end
                m_pos = fe ? 0 : m_pos + 1;
            end
        end
        e_ready = !m_pend;
    end

    always @(negedge clk) begin
        if (e_valid) begin
            chk("model_an", 32'(o_an), 32'(e_an));
            chk("model_seg", 32'(o_seg), 32'(e_seg));
            chk("model_ready", 32'(o_ready), 32'(e_ready));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [N-1:0] an, input logic [6:0] seg);
        chk({name, "_an"}, 32'(o_an), 32'(an));
        chk({name, "_seg"}, 32'(o_seg), 32'(seg));
    endtask

    task automatic load(input logic [15:0] v);
        i_valid = 1'b1; i_value = v;
        cyc(1);
        i_valid = 1'b0;
    endtask

    task automatic clear_pulse();
        i_clear = 1'b1;
        cyc(1);
        i_clear = 1'b0;
    endtask

    initial begin
        // Reset and idle
        cyc(2);
        i_rst = 1'b0;
        lit("rst", 4'b1111, 7'h7F);
        chk("rst_ready", 32'(o_ready), 32'd1);
        cyc(3);
        lit("idle", 4'b1111, 7'h7F);

        // Plain scan of 12AF
        load(16'h12AF);
        cyc(1); lit("d0_F", 4'b1110, 7'b0001110);
        cyc(4); lit("d1_A", 4'b1101, 7'b0001000);
        cyc(4); lit("d2_2", 4'b1011, 7'b0100100);
        cyc(4); lit("d3_1", 4'b0111, 7'b1111001);
        cyc(4); lit("wrap_F", 4'b1110, 7'b0001110);

        // Leading-zero blanking
        clear_pulse();
        i_blank_lz = 1'b1;
        load(16'h0030);
        cyc(1); lit("lz_d0", 4'b1110, 7'b1000000);
        cyc(4); lit("lz_d1", 4'b1101, 7'b0110000);
        cyc(4); lit("lz_d2", 4'b1111, 7'h7F);
        cyc(4); lit("lz_d3", 4'b1111, 7'h7F);
        clear_pulse();
        load(16'h0000);
        cyc(1); lit("zero_d0", 4'b1110, 7'b1000000);
        cyc(4); lit("zero_d1", 4'b1111, 7'h7F);

        // Mid-frame update waits for frame end
        clear_pulse();
        i_blank_lz = 1'b0;
        load(16'h12AF);
        cyc(4);
        load(16'hBEEF);
        chk("pend_ready", 32'(o_ready), 32'd0);
        cyc(10);
        chk("pend_hold_ready", 32'(o_ready), 32'd0);
        lit("pend_old_d3", 4'b0111, 7'b1111001);
        cyc(1);
        chk("commit_ready", 32'(o_ready), 32'd1);
        cyc(1); lit("commit_d0", 4'b1110, 7'b0001110);

        // Accept on the frame_end cycle bypasses the shadow
        cyc(14);
        load(16'h3456);
        chk("bypass_ready", 32'(o_ready), 32'd1);
        lit("bypass_old_d3", 4'b0111, 7'h03);
        cyc(1); lit("bypass_d0", 4'b1110, 7'h02);
        cyc(4); lit("bypass_d1", 4'b1101, 7'h12);

        // Clear while pending discards the pending value
        load(16'h789A);
        chk("pend2_ready", 32'(o_ready), 32'd0);
        clear_pulse();
        chk("clr_ready", 32'(o_ready), 32'd1);
        lit("clr_last_lit", 4'b1101, 7'h12);
        cyc(1); lit("clr_off", 4'b1111, 7'h7F);
        cyc(20); lit("clr_stay_off", 4'b1111, 7'h7F);
        load(16'h0001);
        cyc(1); lit("after_clr_d0", 4'b1110, 7'h79);
        cyc(4); lit("after_clr_d1", 4'b1101, 7'h40);

        // Reset mid-scan
        i_rst = 1'b1;
        cyc(1);
        i_rst = 1'b0;
        lit("rst2", 4'b1111, 7'h7F);
        chk("rst2_ready", 32'(o_ready), 32'd1);
        cyc(5); lit("rst2_idle", 4'b1111, 7'h7F);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_hex_scan_ctrl
`default_nettype wire
